// File: rtl/invaders_pkg.sv
// Shared geometry, state encoding and scoring for the alien formation hit logic.
// Row 0 is the top row of the formation grid.
package invaders_pkg;

  localparam int ROWS    = 5;
  localparam int COLS    = 11;
  localparam int ALIEN_W = 16;
  localparam int ALIEN_H = 8;
  localparam int PITCH_X = 24;
  localparam int PITCH_Y = 16;

  localparam int CELLS  = ROWS * COLS;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int CELL_W = $clog2(CELLS);

  typedef enum logic {
    ARMED   = 1'b0,
    EXPLODE = 1'b1
  } hit_state_t;

  // Points awarded per kill: the top row is worth the most.
  function automatic logic [4:0] row_points(input logic [ROW_W-1:0] row);
    if (row == '0) begin
      return 5'd30;
    end else if (row <= ROW_W'(2)) begin
      return 5'd20;
    end else begin
      return 5'd10;
    end
  endfunction

endpackage

// File: rtl/invader_cell_locate.sv
// Maps a bullet tip onto the formation grid: which cell it is over, and whether
// it lies on the sprite itself rather than in the gap between sprites.
module invader_cell_locate
  import invaders_pkg::*;
(
  input  logic [9:0]       bullet_x_i,
  input  logic [9:0]       bullet_y_i,
  input  logic [9:0]       formation_x_i,
  input  logic [9:0]       formation_y_i,
  output logic             cell_valid_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o
);

  localparam logic [9:0] PX   = 10'(PITCH_X);
  localparam logic [9:0] PY   = 10'(PITCH_Y);
  localparam logic [9:0] AW   = 10'(ALIEN_W);
  localparam logic [9:0] AH   = 10'(ALIEN_H);
  localparam logic [9:0] NCOL = 10'(COLS);
  localparam logic [9:0] NROW = 10'(ROWS);

  logic [9:0] dx;
  logic [9:0] dy;
  logic [9:0] col_full;
  logic [9:0] row_full;
  logic [9:0] x_off;
  logic [9:0] y_off;

  always_comb begin
    dx       = bullet_x_i - formation_x_i;
    dy       = bullet_y_i - formation_y_i;
    col_full = dx / PX;
    row_full = dy / PY;
    x_off    = dx % PX;
    y_off    = dy % PY;

    // The subtraction wraps when the bullet is left of / above the grid, so gate it out.
    cell_valid_o = (bullet_x_i >= formation_x_i) && (bullet_y_i >= formation_y_i) &&
                   (col_full < NCOL) && (row_full < NROW) &&
                   (x_off < AW) && (y_off < AH);

    row_o = row_full[ROW_W-1:0];
    col_o = col_full[COL_W-1:0];
  end

endmodule

// File: rtl/invader_hit_detect.sv
// Once-per-frame bullet vs. formation collision: kills the struck alien, pulses hit,
// accumulates a saturating score and runs the explosion sprite timer.
module invader_hit_detect
  import invaders_pkg::*;
#(
  parameter int EXPLODE_FRAMES = 8,
  parameter int SCORE_W        = 16
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [9:0]           bullet_X,
  input  logic [9:0]           bullet_Y,
  input  logic                 bullet_on_screen,
  input  logic [9:0]           formation_X,
  input  logic [9:0]           formation_Y,
  input  logic                 new_wave,
  output logic                 hit,
  output logic [CELLS-1:0]     alive_mask,
  output logic                 all_dead,
  output logic [SCORE_W-1:0]   score,
  output logic                 explode_active,
  output logic [9:0]           explode_X,
  output logic [9:0]           explode_Y
);

  localparam int               CNT_W    = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [9:0]       PX       = 10'(PITCH_X);
  localparam logic [9:0]       PY       = 10'(PITCH_Y);

  logic               cell_valid;
  logic [ROW_W-1:0]   loc_row;
  logic [COL_W-1:0]   loc_col;
  logic [CELL_W-1:0]  cell_idx;
  logic               strike;
  logic [CELLS-1:0]   kill;

  logic [CELLS-1:0]   alive_q,   alive_d;
  logic               hit_q;
  logic               all_dead_q;
  logic [SCORE_W-1:0] score_q,   score_d;
  logic [SCORE_W:0]   score_sum;
  hit_state_t         state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [9:0]         ex_x_q,    ex_x_d;
  logic [9:0]         ex_y_q,    ex_y_d;

  invader_cell_locate u_locate (
    .bullet_x_i    (bullet_X),
    .bullet_y_i    (bullet_Y),
    .formation_x_i (formation_X),
    .formation_y_i (formation_Y),
    .cell_valid_o  (cell_valid),
    .row_o         (loc_row),
    .col_o         (loc_col)
  );

  // The ~hit_q term keeps a bullet still over the cell during the pulse from scoring twice.
  always_comb begin
    cell_idx = CELL_W'(loc_row) * CELL_W'(COLS) + CELL_W'(loc_col);
    strike   = bullet_on_screen & cell_valid & alive_q[cell_idx] & ~hit_q & ~new_wave;
  end

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_kill
    assign kill[gi] = strike && (cell_idx == CELL_W'(gi));
  end

  always_comb begin
    alive_d   = new_wave ? '1 : (alive_q & ~kill);
    score_sum = {1'b0, score_q} + (SCORE_W + 1)'(row_points(loc_row));
    score_d   = score_q;
    ex_x_d    = ex_x_q;
    ex_y_d    = ex_y_q;
    if (strike) begin
      score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      ex_x_d  = formation_X + 10'(loc_col) * PX;
      ex_y_d  = formation_Y + 10'(loc_row) * PY;
    end
  end

  // A strike during an explosion restarts it at the new cell with a full count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (new_wave) begin
      state_d = ARMED;
      cnt_d   = '0;
    end else if (strike) begin
      state_d = EXPLODE;
      cnt_d   = CNT_FULL;
    end else begin
      case (state_q)
        EXPLODE: begin
          if (cnt_q == '0) begin
            state_d = ARMED;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ARMED;
        end
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      alive_q    <= '1;
      hit_q      <= 1'b0;
      all_dead_q <= 1'b0;
      score_q    <= '0;
      state_q    <= ARMED;
      cnt_q      <= '0;
      ex_x_q     <= '0;
      ex_y_q     <= '0;
    end else begin
      alive_q    <= alive_d;
      hit_q      <= strike;
      all_dead_q <= new_wave ? 1'b0 : (alive_q == '0);
      score_q    <= score_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_x_q     <= ex_x_d;
      ex_y_q     <= ex_y_d;
    end
  end

  assign hit            = hit_q;
  assign alive_mask     = alive_q;
  assign all_dead       = all_dead_q;
  assign score          = score_q;
  assign explode_active = (state_q == EXPLODE);
  assign explode_X      = ex_x_q;
  assign explode_Y      = ex_y_q;

endmodule

// File: tb/tb_invader_hit_detect.sv
// Bench for invader_hit_detect: directed frame scenarios plus random bullets, all
// compared against a frame-level model of the formation, score and explosion timer.
module tb_invader_hit_detect;
  import invaders_pkg::*;

  localparam int NC = ROWS * COLS;
  localparam int OW = 39 + NC;
  localparam logic [OW-1:0] RESET_VEC = {39'd0, {NC{1'b1}}};

  logic          frame_clk = 1'b0;
  logic          Reset;
  logic [9:0]    bullet_X, bullet_Y, formation_X, formation_Y;
  logic          bullet_on_screen, new_wave;
  logic          hit, all_dead, explode_active;
  logic [NC-1:0] alive_mask;
  logic [15:0]   score;
  logic [9:0]    explode_X, explode_Y;
  logic [OW-1:0] obs;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  invader_hit_detect #(.EXPLODE_FRAMES(8), .SCORE_W(16)) dut (
    .frame_clk        (frame_clk),
    .Reset            (Reset),
    .bullet_X         (bullet_X),
    .bullet_Y         (bullet_Y),
    .bullet_on_screen (bullet_on_screen),
    .formation_X      (formation_X),
    .formation_Y      (formation_Y),
    .new_wave         (new_wave),
    .hit              (hit),
    .alive_mask       (alive_mask),
    .all_dead         (all_dead),
    .score            (score),
    .explode_active   (explode_active),
    .explode_X        (explode_X),
    .explode_Y        (explode_Y)
  );

  always #5 frame_clk = ~frame_clk;

  assign obs = {hit, all_dead, explode_active, explode_X, explode_Y, score, alive_mask};

  // ---------------- reference model (frame level) ----------------
  bit m_alive [ROWS][COLS];
  int m_score, m_left, m_ex_x, m_ex_y;
  bit m_hit, m_all_dead;

  task automatic m_reset();
    foreach (m_alive[r, c]) m_alive[r][c] = 1'b1;
    m_score = 0; m_left = 0; m_ex_x = 0; m_ex_y = 0;
    m_hit = 1'b0; m_all_dead = 1'b0;
  endtask

  function automatic int pts(int r);
    return (r == 0) ? 30 : ((r <= 2) ? 20 : 10);
  endfunction

  task automatic m_step();
    int bx, by, fx, fy, dx, dy, r, c, live;
    bit cand, strike;
    bx = int'(bullet_X); by = int'(bullet_Y);
    fx = int'(formation_X); fy = int'(formation_Y);
    cand = 1'b0; strike = 1'b0; r = 0; c = 0; live = 0;
    if (bx >= fx && by >= fy) begin
      dx = bx - fx; dy = by - fy;
      if (dx / PITCH_X < COLS && dy / PITCH_Y < ROWS &&
          dx % PITCH_X < ALIEN_W && dy % PITCH_Y < ALIEN_H) begin
        cand = 1'b1; c = dx / PITCH_X; r = dy / PITCH_Y;
      end
    end
    if (cand && bullet_on_screen && !m_hit && !new_wave)
      strike = m_alive[r][c];
    foreach (m_alive[i, j]) live += int'(m_alive[i][j]);
    if (new_wave) begin
      foreach (m_alive[i, j]) m_alive[i][j] = 1'b1;
      m_all_dead = 1'b0; m_hit = 1'b0; m_left = 0;
    end else begin
      m_all_dead = (live == 0);
      m_hit = strike;
      if (strike) begin
        m_alive[r][c] = 1'b0;
        m_score = (m_score + pts(r) > 65535) ? 65535 : m_score + pts(r);
        m_ex_x = (fx + c * PITCH_X) % 1024;
        m_ex_y = (fy + r * PITCH_Y) % 1024;
        m_left = 8;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
  endtask

  function automatic logic [OW-1:0] exp_vec();
    logic [NC-1:0] mask;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mask[r*COLS+c] = m_alive[r][c];
    return {m_hit, m_all_dead, (m_left > 0), 10'(m_ex_x), 10'(m_ex_y), 16'(m_score), mask};
  endfunction

  task automatic step();
    m_step();
    @(posedge frame_clk);
    #1;
    step_no++;
  endtask

  task automatic aim(input int r, input int c);
    bullet_X = 10'(int'(formation_X) + c * PITCH_X + $urandom_range(ALIEN_W - 1, 0));
    bullet_Y = 10'(int'(formation_Y) + r * PITCH_Y + $urandom_range(ALIEN_H - 1, 0));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b1; bullet_X = '0; bullet_Y = '0; formation_X = '0; formation_Y = '0;
    bullet_on_screen = 1'b0; new_wave = 1'b0;
    m_reset();
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      failures++; $display("FAIL reset_async got=%h exp=%h", obs, RESET_VEC);
    end
    @(posedge frame_clk); #1;
    checks++;
    if (obs !== RESET_VEC) begin
      failures++; $display("FAIL reset_held got=%h exp=%h", obs, RESET_VEC);
    end
    Reset = 1'b0;
    $display("reset: outputs=%h", obs);
  endtask

  task automatic test_single_strike();
    formation_X = 10'd100; formation_Y = 10'd50;
    bullet_X = 10'd101; bullet_Y = 10'd51; bullet_on_screen = 1'b1;
    step();
    checks++;
    if (hit !== 1'b1 || alive_mask[0] !== 1'b0 || score !== 16'd30 ||
        explode_X !== 10'd100 || explode_Y !== 10'd50 || explode_active !== 1'b1) begin
      failures++;
      $display("FAIL strike_cell00 got hit=%b m0=%b score=%0d ex=(%0d,%0d) act=%b exp hit=1 m0=0 score=30 ex=(100,50) act=1",
               hit, alive_mask[0], score, explode_X, explode_Y, explode_active);
    end
    $display("strike (0,0): hit=%b score=%0d ex=(%0d,%0d)", hit, score, explode_X, explode_Y);
    bullet_on_screen = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      step();
      checks++;
      if (hit !== 1'b0 || explode_active !== (k <= 8) || obs !== exp_vec()) begin
        failures++;
        $display("FAIL explode_len frame=%0d got hit=%b act=%b exp hit=0 act=%b", k, hit, explode_active, (k <= 8));
      end
    end
  endtask

  task automatic test_gap_and_row();
    bullet_X = 10'd116; bullet_Y = 10'd51; bullet_on_screen = 1'b1;
    step();
    checks++;
    if (hit !== 1'b0 || score !== 16'd30) begin
      failures++; $display("FAIL gap_no_hit got hit=%b score=%0d exp hit=0 score=30", hit, score);
    end
    bullet_X = 10'd124; bullet_Y = 10'd73;
    step();
    checks++;
    if (hit !== 1'b1 || score !== 16'd50 || alive_mask[12] !== 1'b0 ||
        explode_X !== 10'd124 || explode_Y !== 10'd66) begin
      failures++;
      $display("FAIL strike_cell11 got hit=%b score=%0d m12=%b ex=(%0d,%0d) exp hit=1 score=50 m12=0 ex=(124,66)",
               hit, score, alive_mask[12], explode_X, explode_Y);
    end
    $display("strike (1,1): hit=%b score=%0d", hit, score);
  endtask

  task automatic test_dead_cell();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (hit !== 1'b0 || score !== 16'd50 || obs !== exp_vec()) begin
        failures++; $display("FAIL dead_cell frame=%0d got hit=%b score=%0d exp hit=0 score=50", k, hit, score);
      end
    end
    bullet_on_screen = 1'b0;
    step();
  endtask

  task automatic test_restart();
    bullet_X = 10'd177; bullet_Y = 10'd85; bullet_on_screen = 1'b1;
    step();
    bullet_on_screen = 1'b0; formation_X = 10'd104;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (explode_X !== 10'd172 || explode_Y !== 10'd82 || explode_active !== 1'b1) begin
        failures++;
        $display("FAIL explode_frozen got ex=(%0d,%0d) act=%b exp ex=(172,82) act=1", explode_X, explode_Y, explode_active);
      end
    end
    bullet_X = 10'd226; bullet_Y = 10'd51; bullet_on_screen = 1'b1;
    step();
    checks++;
    if (hit !== 1'b1 || explode_X !== 10'd224 || explode_Y !== 10'd50 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL restart_move got hit=%b ex=(%0d,%0d) exp hit=1 ex=(224,50)", hit, explode_X, explode_Y);
    end
    $display("restart strike (0,5): ex=(%0d,%0d)", explode_X, explode_Y);
    bullet_on_screen = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      step();
      checks++;
      if (explode_active !== (k <= 8) || obs !== exp_vec()) begin
        failures++; $display("FAIL restart_len frame=%0d got act=%b exp act=%b", k, explode_active, (k <= 8));
      end
    end
    formation_X = 10'd100;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      if (k % 50 == 0) begin
        formation_X = 10'($urandom_range(700, 0));
        formation_Y = 10'($urandom_range(400, 0));
      end
      if ($urandom_range(9, 0) < 7) begin
        bullet_X = 10'(int'(formation_X) + $urandom_range(COLS * PITCH_X, 0));
        bullet_Y = 10'(int'(formation_Y) + $urandom_range(ROWS * PITCH_Y, 0));
      end else begin
        bullet_X = 10'($urandom_range(1023, 0));
        bullet_Y = 10'($urandom_range(1023, 0));
      end
      bullet_on_screen = ($urandom_range(9, 0) < 8);
      new_wave = ($urandom_range(99, 0) < 3);
      step();
      checks++;
      if (obs !== exp_vec()) begin
        failures++; bad++;
        if (bad <= 5) $display("FAIL random step=%0d got=%h exp=%h", k, obs, exp_vec());
      end
    end
    new_wave = 1'b0; bullet_on_screen = 1'b0;
    $display("random: 600 frames, score=%0d", score);
  endtask

  task automatic test_clear_wave();
    formation_X = 10'd100; formation_Y = 10'd50;
    new_wave = 1'b1; step(); new_wave = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        aim(r, c); bullet_on_screen = 1'b1;
        step();
        checks++;
        if (hit !== 1'b1 || all_dead !== 1'b0 || obs !== exp_vec()) begin
          failures++; $display("FAIL clear_kill cell=(%0d,%0d) got hit=%b all_dead=%b exp hit=1 all_dead=0", r, c, hit, all_dead);
        end
        bullet_on_screen = 1'b0;
        step();
        checks++;
        if (all_dead !== (r == ROWS - 1 && c == COLS - 1) || obs !== exp_vec()) begin
          failures++; $display("FAIL all_dead_timing cell=(%0d,%0d) got all_dead=%b", r, c, all_dead);
        end
      end
    end
    step();
    checks++;
    if (all_dead !== 1'b1 || alive_mask !== '0) begin
      failures++; $display("FAIL all_dead_hold got all_dead=%b mask=%h exp all_dead=1 mask=0", all_dead, alive_mask);
    end
    $display("wave cleared: all_dead=%b score=%0d", all_dead, score);
    aim(0, 0); bullet_on_screen = 1'b1; new_wave = 1'b1;
    step();
    checks++;
    if (alive_mask !== {NC{1'b1}} || hit !== 1'b0 || all_dead !== 1'b0 ||
        explode_active !== 1'b0 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL new_wave got mask=%h hit=%b all_dead=%b act=%b score=%0d", alive_mask, hit, all_dead, explode_active, score);
    end
    aim(1, 0);
    step();
    checks++;
    if (hit !== 1'b0 || alive_mask[COLS] !== 1'b1 || obs !== exp_vec()) begin
      failures++; $display("FAIL new_wave_priority got hit=%b m11=%b exp hit=0 m11=1", hit, alive_mask[COLS]);
    end
    new_wave = 1'b0;
    step();
    checks++;
    if (hit !== 1'b1 || alive_mask[COLS] !== 1'b0 || obs !== exp_vec()) begin
      failures++; $display("FAIL post_wave_strike got hit=%b m11=%b exp hit=1 m11=0", hit, alive_mask[COLS]);
    end
    bullet_on_screen = 1'b0;
    step();
  endtask

  task automatic test_saturate_and_reset();
    int bad, fr, fc;
    bit found;
    bad = 0;
    formation_X = 10'd100; formation_Y = 10'd50;
    while (m_score < 65506) begin
      found = 1'b0; fr = 0; fc = 0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (!found && m_alive[r][c]) begin found = 1'b1; fr = r; fc = c; end
      if (!found) begin
        new_wave = 1'b1; step(); new_wave = 1'b0;
      end else begin
        aim(fr, fc); bullet_on_screen = 1'b1; step();
        bullet_on_screen = 1'b0; step();
      end
      checks++;
      if (obs !== exp_vec()) begin
        failures++; bad++;
        if (bad <= 5) $display("FAIL score_climb got=%h exp=%h", obs, exp_vec());
      end
    end
    new_wave = 1'b1; step(); new_wave = 1'b0;
    $display("score before saturation: %0d", score);
    aim(0, 0); bullet_on_screen = 1'b1;
    step();
    checks++;
    if (score !== 16'hFFFF || hit !== 1'b1 || obs !== exp_vec()) begin
      failures++; $display("FAIL saturate got score=%h hit=%b exp score=ffff hit=1", score, hit);
    end
    bullet_on_screen = 1'b0; step();
    aim(0, 1); bullet_on_screen = 1'b1;
    step();
    checks++;
    if (score !== 16'hFFFF || hit !== 1'b1 || alive_mask[1] !== 1'b0) begin
      failures++; $display("FAIL saturate_hold got score=%h hit=%b m1=%b exp score=ffff hit=1 m1=0", score, hit, alive_mask[1]);
    end
    $display("saturated: score=%h", score);
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      failures++; $display("FAIL reset_mid_explode got=%h exp=%h", obs, RESET_VEC);
    end
    m_reset();
    bullet_on_screen = 1'b0;
    @(posedge frame_clk); #1;
    Reset = 1'b0;
    $display("reset mid-explosion: outputs=%h", obs);
  endtask

  initial begin
    test_reset();
    test_single_strike();
    test_gap_and_row();
    test_dead_cell();
    test_restart();
    test_random();
    test_clear_wave();
    test_saturate_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
